// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and counter sizing.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to hold values 0..w (ceil(log2(w+1))).
  function automatic int unsigned count_width(input int unsigned w);
    int unsigned n;
    n = 0;
    while ((64'd1 << n) < (64'(w) + 64'd1)) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rc_adder.sv
// Width-bit ripple-carry adder with carry out; carry chain is bit-serial by construction.
module rc_adder #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o
);

  logic carry;

  always_comb begin
    result_o = '0;
    carry    = 1'b0;
    for (int i = 0; i < int'(Width); i++) begin
      result_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry       = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    carry_o = carry;
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier sharing one rc_adder, one step per clock.
// Optional: define SHIFT_ADD_MULT_ZERO_SKIP_EN to bypass CALC when either operand is zero.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  localparam int unsigned CntW = count_width(Width);

  state_e             state_q, state_d;
  logic [Width-1:0]   mcand_q, mcand_d;
  logic [2*Width-1:0] product_q, product_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [Width-1:0]   hi, lo, sum;
  logic               carry;

  assign hi = product_q[2*Width-1:Width];
  assign lo = product_q[Width-1:0];

  rc_adder #(.Width(Width)) u_rc_adder (
    .a_i      (hi),
    .b_i      (mcand_q),
    .result_o (sum),
    .carry_o  (carry)
  );

  // Next-state and datapath update; busy/done are registered from the next state.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    count_d   = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcand_d   = a_i;
          product_d = {Width'(0), b_i};
          count_d   = CntW'(Width);
          state_d   = ST_CALC;
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
          if ((a_i == '0) || (b_i == '0)) begin
            product_d = '0;
            state_d   = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        if (lo[0]) begin
          product_d = {carry, sum, lo[Width-1:1]};
        end else begin
          product_d = {1'b0, hi, lo[Width-1:1]};
        end
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      product_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule
